// File: rtl/net_pkg.sv
// Shared FSM state encoding and run-length helper for the network sequencer.
package net_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_RUN,
    ST_SETTLE,
    ST_REPORT
  } state_t;

  // Run window length: pixels * 2**(WIDTH+2) network cycles.
  function automatic int unsigned run_cycles(input int unsigned height,
                                             input int unsigned width);
    return height << (width + 2);
  endfunction

endpackage

// File: rtl/edge_counter.sv
// Rising-edge detector feeding a saturating counter; clr also clears the edge history.
module edge_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic             din,
  output logic [CNT_W-1:0] count
);

  logic prev;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      prev  <= 1'b0;
      count <= '0;
    end else if (en) begin
      prev <= din;
      if (din && !prev && (count != '1)) begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/network_sequencer.sv
// Feeds one pixel frame to a spiking network, times the run window, waits for
// idle (bounded by GUARD) and hands back the spike count through a ready/valid port.
module network_sequencer
  import net_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned HEIGHT = 7,
  parameter int unsigned GUARD  = 16,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [HEIGHT-1:0] in_pixels,
  output logic [HEIGHT-1:0] net_pixels,
  output logic              net_start,
  input  logic [1:0]        net_out,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [CNT_W-1:0]  res_count,
  output logic              res_spiked,
  output logic              res_timeout
);

  localparam int unsigned RUN_CYCLES = run_cycles(HEIGHT, WIDTH);
  localparam int unsigned TW         = $clog2(RUN_CYCLES + GUARD) + 1;
  localparam logic [TW-1:0] RUN_LAST   = TW'(RUN_CYCLES - 1);
  localparam logic [TW-1:0] GUARD_LAST = TW'(GUARD - 1);

  state_t        state, state_next;
  logic [TW-1:0] timer;
  logic          capture;
  logic          cnt_clr;
  logic          cnt_en;
  logic          timer_clr;
  logic          timeout_set;

  always_comb begin
    state_next  = state;
    in_ready    = 1'b0;
    net_start   = 1'b0;
    res_valid   = 1'b0;
    capture     = 1'b0;
    cnt_clr     = 1'b0;
    cnt_en      = 1'b0;
    timer_clr   = 1'b0;
    timeout_set = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          capture    = 1'b1;
          cnt_clr    = 1'b1;
          timer_clr  = 1'b1;
          state_next = ST_START;
        end
      end
      ST_START: begin
        net_start  = 1'b1;
        cnt_clr    = 1'b1;
        timer_clr  = 1'b1;
        state_next = ST_RUN;
      end
      ST_RUN: begin
        cnt_en = 1'b1;
        if (timer == RUN_LAST) begin
          timer_clr  = 1'b1;
          state_next = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        // Edges are still counted on the cycle that exits, idle or timed out.
        cnt_en = 1'b1;
        if (net_out[1]) begin
          state_next = ST_REPORT;
        end else if (timer == GUARD_LAST) begin
          timeout_set = 1'b1;
          state_next  = ST_REPORT;
        end
      end
      ST_REPORT: begin
        res_valid = 1'b1;
        if (res_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      timer       <= '0;
      net_pixels  <= '0;
      res_spiked  <= 1'b0;
      res_timeout <= 1'b0;
    end else begin
      state <= state_next;
      timer <= (timer_clr || !cnt_en) ? '0 : timer + 1'b1;
      if (capture) begin
        net_pixels  <= in_pixels;
        res_spiked  <= 1'b0;
        res_timeout <= 1'b0;
      end else begin
        if (cnt_en && net_out[0]) res_spiked <= 1'b1;
        if (timeout_set) res_timeout <= 1'b1;
      end
    end
  end

  edge_counter #(
    .CNT_W(CNT_W)
  ) u_edge_counter (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .din  (net_out[0]),
    .count(res_count)
  );

endmodule

// File: tb/tb_network_sequencer.sv
// Directed scoreboard bench: expected results are modelled at frame acceptance
// and compared when res_valid appears; a second instance covers count saturation.
module tb_network_sequencer;

  localparam int RUN_M   = 3 * 16;   // HEIGHT=3, WIDTH=2
  localparam int GUARD_M = 4;
  localparam int RUN_S   = 3 * 256;  // HEIGHT=3, WIDTH=6

  typedef struct {
    logic [7:0] cnt;
    bit         spk;
    bit         to;
    int         vk;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, net_start, res_valid, res_ready;
  logic [2:0] in_pixels, net_pixels;
  logic [1:0] net_out;
  logic [7:0] res_count;
  logic       res_spiked, res_timeout;

  logic       s_in_valid, s_in_ready, s_net_start, s_res_valid, s_res_ready;
  logic [2:0] s_in_pixels, s_net_pixels;
  logic [1:0] s_net_out;
  logic [7:0] s_res_count;
  logic       s_res_spiked, s_res_timeout;

  int   nchk  = 0;
  int   npass = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  network_sequencer #(.WIDTH(2), .HEIGHT(3), .GUARD(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_pixels(in_pixels), .net_pixels(net_pixels), .net_start(net_start),
    .net_out(net_out), .res_valid(res_valid), .res_ready(res_ready),
    .res_count(res_count), .res_spiked(res_spiked), .res_timeout(res_timeout)
  );

  network_sequencer #(.WIDTH(6), .HEIGHT(3), .GUARD(4), .CNT_W(8)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_pixels(s_in_pixels), .net_pixels(s_net_pixels), .net_start(s_net_start),
    .net_out(s_net_out), .res_valid(s_res_valid), .res_ready(s_res_ready),
    .res_count(s_res_count), .res_spiked(s_res_spiked), .res_timeout(s_res_timeout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Spike stimulus; k is the cycle offset from the acceptance cycle.
  function automatic bit f0(input int mode, input int k);
    case (mode)
      1:       return (k >= 2) && (k <= 1 + RUN_M) && (((k - 2) % 8) == 3);
      2:       return (k % 2) == 1;
      3:       return (k == 1) || (k == 2 + RUN_M) || (k == 6 + RUN_M);
      default: return 1'b0;
    endcase
  endfunction

  task automatic do_frame(input logic [2:0] pix, input int mode, input bit idle,
                          input int delay, input bit pulse);
    exp_t e, got;
    int   k, end_k, guard;
    bit   prev, b, seen;
    end_k = 1 + RUN_M + (idle ? 1 : GUARD_M);
    e.cnt = 8'd0; e.spk = 1'b0; e.to = !idle; e.vk = end_k + 1;
    prev  = 1'b0;
    for (int c = 2; c <= end_k; c++) begin
      b = f0(mode, c);
      if (b) e.spk = 1'b1;
      if (b && !prev && e.cnt != 8'hFF) e.cnt = e.cnt + 8'd1;
      prev = b;
    end
    guard = 0;
    while (in_ready !== 1'b1 && guard < 100) begin
      tick();
      guard++;
    end
    chk("in_ready_idle", in_ready, 1);
    res_ready = (delay == 0);
    in_pixels = pix;
    in_valid  = 1'b1;
    k = 0;
    net_out = {1'b0, f0(mode, k)};
    tick();
    k = 1;
    in_valid = 1'b0;
    net_out  = {1'b0, f0(mode, k)};
    sb.push_back(e);
    chk("net_start", net_start, 1);
    chk("net_pixels", net_pixels, pix);
    chk("in_ready_busy", in_ready, 0);
    seen = 1'b0;
    while (!seen && k < 200) begin
      tick();
      k++;
      in_valid  = pulse && (k == 20);
      in_pixels = (pulse && k == 20) ? ~pix : pix;
      net_out   = {idle && (k >= 2 + RUN_M), f0(mode, k)};
      if (res_valid === 1'b1) begin
        seen = 1'b1;
      end else begin
        chk("net_start_low", net_start, 0);
        chk("in_ready_low", in_ready, 0);
      end
    end
    chk("res_valid_seen", seen, 1);
    if (seen && sb.size() > 0) begin
      got = sb.pop_front();
      chk("res_valid_cycle", k, got.vk);
      chk("res_count", res_count, got.cnt);
      chk("res_spiked", res_spiked, got.spk);
      chk("res_timeout", res_timeout, got.to);
      chk("net_pixels_held", net_pixels, pix);
      for (int d = 0; d < delay; d++) begin
        tick();
        chk("res_valid_hold", res_valid, 1);
        chk("res_count_hold", res_count, got.cnt);
        chk("res_spiked_hold", res_spiked, got.spk);
        chk("in_ready_report", in_ready, 0);
      end
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    net_out   = 2'b00;
    chk("res_valid_done", res_valid, 0);
    chk("in_ready_done", in_ready, 1);
  endtask

  task automatic chk_reset_state();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_net_pixels", net_pixels, 0);
    chk("rst_net_start", net_start, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_count", res_count, 0);
    chk("rst_res_spiked", res_spiked, 0);
    chk("rst_res_timeout", res_timeout, 0);
  endtask

  initial begin
    int  k;
    bit  b, prev, seen;
    logic [7:0] ecnt;
    rst_n = 1'b0;
    in_valid = 1'b0; in_pixels = 3'b000; net_out = 2'b00; res_ready = 1'b0;
    s_in_valid = 1'b0; s_in_pixels = 3'b000; s_net_out = 2'b00; s_res_ready = 1'b1;
    tick();
    tick();
    chk_reset_state();
    rst_n = 1'b1;

    do_frame(3'b111, 1, 1'b1, 0, 1'b0);   // 6 rising edges, idle reported
    do_frame(3'b000, 0, 1'b1, 2, 1'b0);   // silent network
    do_frame(3'b010, 0, 1'b0, 1, 1'b0);   // idle never seen -> timeout
    do_frame(3'b110, 3, 1'b0, 3, 1'b0);   // spikes outside window ignored
    do_frame(3'b101, 1, 1'b1, 10, 1'b1);  // slow consumer, in_valid pulse mid-run

    // Reset during RUN with a non-zero count accumulated.
    in_pixels = 3'b101;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    for (k = 1; k < 22; k++) begin
      net_out = {1'b0, f0(2, k)};
      tick();
    end
    chk("pre_reset_count_nonzero", (res_count != 8'd0), 1);
    rst_n = 1'b0;
    tick();
    net_out = 2'b00;
    chk_reset_state();
    rst_n = 1'b1;
    do_frame(3'b011, 2, 1'b1, 0, 1'b0);

    // Saturation on the wide-run instance: one rising edge every other cycle.
    s_in_pixels = 3'b111;
    s_in_valid  = 1'b1;
    tick();
    s_in_valid = 1'b0;
    k = 1;
    chk("sat_net_start", s_net_start, 1);
    ecnt = 8'd0;
    prev = 1'b0;
    for (int c = 2; c <= 2 + RUN_S; c++) begin
      b = (c % 2) == 1;
      if (b && !prev && ecnt != 8'hFF) ecnt = ecnt + 8'd1;
      prev = b;
    end
    seen = 1'b0;
    while (!seen && k < 1000) begin
      s_net_out = {1'b1, k[0]};
      tick();
      k++;
      if (s_res_valid === 1'b1) seen = 1'b1;
    end
    s_net_out = {1'b1, k[0]};
    chk("sat_res_valid_seen", seen, 1);
    chk("sat_res_valid_cycle", k, 3 + RUN_S);
    chk("sat_res_count", s_res_count, ecnt);
    chk("sat_res_spiked", s_res_spiked, 1);
    chk("sat_res_timeout", s_res_timeout, 0);
    tick();
    chk("sat_in_ready_done", s_in_ready, 1);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
